// File: rtl/pipe_link_fifo.sv
// Elastic DEPTH-entry valid/rdy link between pipeline stages with flush and occupancy count.
// Latency: 1 cycle push-to-valid; zero-latency pass-through when PIPE_LINK_BYPASS_EN is defined and the link is empty.
// Backpressure: src_rdy_out = !full & !flush_in, independent of dst_rdy_in (no comb rdy path).
module pipe_link_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              flush_in,
    input  logic              src_valid_in,
    input  logic [DATA_W-1:0] src_data_in,
    output logic              src_rdy_out,
    output logic              dst_valid_out,
    output logic [DATA_W-1:0] dst_data_out,
    input  logic              dst_rdy_in,
    output logic [CNT_W-1:0]  count_out,
    output logic              full_out,
    output logic              empty_out
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    assign full        = (count == CNT_W'(DEPTH));
    assign empty       = (count == '0);
    assign src_rdy_out = !full && !flush_in;
    assign count_out   = count;
    assign full_out    = full;
    assign empty_out   = empty;

`ifdef PIPE_LINK_BYPASS_EN
    logic bypass;

    // An empty link with a ready consumer hands the payload straight through without storing it.
    assign bypass        = empty && src_valid_in && dst_rdy_in && !flush_in;
    assign dst_valid_out = (!empty || src_valid_in) && !flush_in;
    assign dst_data_out  = empty ? src_data_in : mem[rd_ptr];
    assign push          = src_valid_in && src_rdy_out && !bypass;
    assign pop           = dst_valid_out && dst_rdy_in && !empty;
`else
    assign dst_valid_out = !empty && !flush_in;
    assign dst_data_out  = mem[rd_ptr];
    assign push          = src_valid_in && src_rdy_out;
    assign pop           = dst_valid_out && dst_rdy_in;
`endif

    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wr_ptr] <= src_data_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in || flush_in) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            assert (!(push && full))
                else $error("pipe_link_fifo: push while full");
            assert (!(pop && empty))
                else $error("pipe_link_fifo: pop while empty");
            assert (count <= CNT_W'(DEPTH))
                else $error("pipe_link_fifo: count exceeds DEPTH");
        end
    end
endmodule

// File: tb/tb_pipe_link_fifo.sv
// Directed bench for pipe_link_fifo (DATA_W=32, DEPTH=4) with a queue scoreboard as reference model.
module tb_pipe_link_fifo;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);
`ifdef PIPE_LINK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk_in = 1'b0;
    logic              reset_in;
    logic              flush_in;
    logic              src_valid_in;
    logic [DATA_W-1:0] src_data_in;
    logic              src_rdy_out;
    logic              dst_valid_out;
    logic [DATA_W-1:0] dst_data_out;
    logic              dst_rdy_in;
    logic [CNT_W-1:0]  count_out;
    logic              full_out;
    logic              empty_out;

    int passed = 0;
    int total  = 0;
    int max_cnt;
    logic [DATA_W-1:0] exp_q[$];

    pipe_link_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .flush_in     (flush_in),
        .src_valid_in (src_valid_in),
        .src_data_in  (src_data_in),
        .src_rdy_out  (src_rdy_out),
        .dst_valid_out(dst_valid_out),
        .dst_data_out (dst_data_out),
        .dst_rdy_in   (dst_rdy_in),
        .count_out    (count_out),
        .full_out     (full_out),
        .empty_out    (empty_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // Drive one cycle, check outputs at the falling edge against the model, then advance the model.
    task automatic step(input string tag, input logic rs, input logic v, input logic [31:0] d,
                        input logic r, input logic f);
        int   m_cnt;
        logic m_empty, m_rdy, m_vld, byp, do_pop, do_push;
        reset_in = rs; src_valid_in = v; src_data_in = d; dst_rdy_in = r; flush_in = f;
        @(negedge clk_in);
        m_cnt   = exp_q.size();
        m_empty = (m_cnt == 0);
        m_rdy   = (m_cnt < DEPTH) && !f;
        m_vld   = (!m_empty || (BYP && v)) && !f;
        chk({tag, ".src_rdy"}, 32'(src_rdy_out), 32'(m_rdy));
        chk({tag, ".dst_valid"}, 32'(dst_valid_out), 32'(m_vld));
        chk({tag, ".count"}, 32'(count_out), 32'(m_cnt));
        chk({tag, ".full"}, 32'(full_out), 32'(m_cnt == DEPTH));
        chk({tag, ".empty"}, 32'(empty_out), 32'(m_empty));
        if (m_vld) chk({tag, ".dst_data"}, dst_data_out, m_empty ? d : exp_q[0]);
        if (int'(count_out) > max_cnt) max_cnt = int'(count_out);
        byp     = BYP && m_empty && v && r && !f;
        do_pop  = m_vld && r && !m_empty;
        do_push = v && m_rdy && !byp;
        @(posedge clk_in);
        if (rs || f) begin
            exp_q.delete();
        end else begin
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(d);
        end
        #1;
    endtask

    initial begin
        logic [31:0] fill_vals [4];
        fill_vals = '{32'h11, 32'h22, 32'h33, 32'h44};
        reset_in = 1'b1; flush_in = 1'b0; src_valid_in = 1'b1; src_data_in = 32'hDEAD; dst_rdy_in = 1'b0;
        @(posedge clk_in); #1;

        // Reset held with a pushing producer: nothing may be stored.
        step("reset0", 1, 1, 32'hDEAD, 0, 0);
        step("reset1", 1, 1, 32'hDEAD, 0, 0);
        step("post_reset", 0, 0, 32'h0, 0, 0);
        chk("post_reset.count_zero", 32'(count_out), 32'd0);

        // Fill with consumer stalled, then a refused fifth push.
        foreach (fill_vals[i]) step("fill", 0, 1, fill_vals[i], 0, 0);
        step("fill_refuse", 0, 1, 32'h55, 0, 0);
        chk("fill.full_after_refuse", 32'(full_out), 32'd1);
        chk("fill.rdy_low", 32'(src_rdy_out), 32'd0);
        for (int i = 0; i < 4; i++) step("drain", 0, 0, 32'h0, 1, 0);
        step("drain_empty", 0, 0, 32'h0, 1, 0);
        chk("drain.empty", 32'(empty_out), 32'd1);

        // Streaming with an always-ready consumer wraps both pointers.
        max_cnt = 0;
        for (int i = 0; i < 10; i++) step("stream", 0, 1, 32'(i), 1, 0);
        step("stream_tail", 0, 0, 32'h0, 1, 0);
        step("stream_tail", 0, 0, 32'h0, 1, 0);
        chk("stream.max_count", 32'(max_cnt), BYP ? 32'd0 : 32'd1);

        // Full with simultaneous pop: push refused this cycle, accepted next.
        for (int i = 0; i < 4; i++) step("fp_fill", 0, 1, 32'hA0 + 32'(i), 0, 0);
        step("fp_pop_refuse", 0, 1, 32'h55, 1, 0);
        chk("fp.count_after_pop", 32'(count_out), 32'd3);
        step("fp_accept", 0, 1, 32'h55, 0, 0);
        chk("fp.count_after_accept", 32'(count_out), 32'd4);
        for (int i = 0; i < 5; i++) step("fp_drain", 0, 0, 32'h0, 1, 0);

        // Flush mid-stream discards entries and the concurrent push of 0xAA.
        for (int i = 0; i < 3; i++) step("fl_fill", 0, 1, 32'hC0 + 32'(i), 0, 0);
        step("flush", 0, 1, 32'hAA, 1, 1);
        chk("flush.count_cleared", 32'(count_out), 32'd0);
        step("fl_push_bb", 0, 1, 32'hBB, 0, 0);
        step("fl_out_bb", 0, 0, 32'h0, 1, 0);
        step("fl_idle", 0, 0, 32'h0, 1, 0);

        // Multi-cycle flush keeps the link empty.
        step("mf_fill", 0, 1, 32'hD0, 0, 0);
        step("mflush0", 0, 1, 32'hD1, 1, 1);
        step("mflush1", 0, 1, 32'hD2, 1, 1);
        step("mf_after", 0, 0, 32'h0, 1, 0);

        // Empty link, ready consumer: pass-through when bypass is built, else 1-cycle latency.
        step("byp_cafe", 0, 1, 32'hCAFE, 1, 0);
        step("byp_after", 0, 0, 32'h0, 1, 0);
        step("byp_idle", 0, 0, 32'h0, 1, 0);
        chk("final.empty", 32'(empty_out), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pipe_link_fifo.md
Name: pipe_link_fifo

Overview:
- Parametrised elastic link between two pipeline stages (fetch→decode, decode→execute, execute→mem, mem→wb).
- Generalises the single valid/rdy stage link to a DEPTH-entry buffer with pipeline flush and an occupancy count.
- Master side connects to the producing stage; slave side connects to the consuming stage.
- The payload is a flat DATA_W-bit vector; callers pack and unpack the stage struct.

Parameters:
- DATA_W, 32: payload width in bits (≥1).
- DEPTH, 2: number of buffer entries (≥1; need not be a power of 2).
- CNT_W, $clog2(DEPTH+1): occupancy counter width (derived; do not override).

Ports:
- clk_in, input, 1: single clock, rising edge.
- reset_in, input, 1: synchronous, active-high reset.
- flush_in, input, 1: pipeline flush; discards all buffered entries.
- src_valid_in, input, 1: producer has data.
- src_data_in, input, DATA_W: producer payload.
- src_rdy_out, output, 1: link can accept data this cycle.
- dst_valid_out, output, 1: link presents valid data.
- dst_data_out, output, DATA_W: payload at head of buffer.
- dst_rdy_in, input, 1: consumer accepts data this cycle.
- count_out, output, CNT_W: number of buffered entries.
- full_out, output, 1: count_out == DEPTH.
- empty_out, output, 1: count_out == 0.

Behaviour:
- Clocking and reset:
  - One clock, clk_in.
  - reset_in is synchronous and active-high; all state updates on the rising edge.
- Reset values:
  - count = 0, rd_ptr = 0, wr_ptr = 0.
  - Storage contents are don't-care.
  - Outputs after reset: src_rdy_out = 1, dst_valid_out = 0, count_out = 0, full_out = 0, empty_out = 1.
  - dst_data_out is don't-care while dst_valid_out = 0.
- Handshake:
  - Push occurs when src_valid_in & src_rdy_out.
  - Pop occurs when dst_valid_out & dst_rdy_in.
- Ready and valid:
  - src_rdy_out = !full & !flush_in.
  - src_rdy_out does not depend on dst_rdy_in, so there is no combinational rdy path through the link.
  - dst_valid_out = !empty & !flush_in (non-bypass build).
- Storage:
  - Circular array of DEPTH entries.
  - Push writes mem[wr_ptr]; pop advances rd_ptr.
  - Each pointer wraps from DEPTH-1 to 0 by explicit compare, not modulo-2^n.
- Count update:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop in the same cycle: unchanged, with both pointers advancing.
- Latency: 1 cycle from push to dst_valid_out in the non-bypass build.
- Full: a push is not accepted (src_rdy_out = 0), even if a pop occurs the same cycle. The slot frees on the next cycle.
- Empty: dst_valid_out = 0 and a pop is impossible.
- Stability: while dst_valid_out = 1 and dst_rdy_in = 0, dst_data_out and dst_valid_out hold until popped or flushed.
- Ordering: strict FIFO; no reordering or duplication.
- Flush:
  - When flush_in = 1 at a clock edge: count, rd_ptr and wr_ptr are cleared to 0.
  - Any push or pop in that cycle is suppressed, because both ready and valid are forced low.
  - Flush has priority over push and pop. Reset has priority over flush.
  - Flush asserted for several cycles keeps the link empty throughout.
- DEPTH = 1: the link behaves as a single-entry stage register, giving at most one transfer every 2 cycles when the consumer always accepts.
- Assertions (simulation only):
  - No push when full.
  - No pop when empty.
  - count_out ≤ DEPTH.

Optional Feature:
- Macro: PIPE_LINK_BYPASS_EN.
- Defined:
  - When count == 0, src_valid_in = 1, dst_rdy_in = 1 and flush_in = 0, the payload passes combinationally (zero latency). The entry is not stored; count and pointers are unchanged.
  - dst_valid_out = (!empty | src_valid_in) & !flush_in.
  - dst_data_out = src_data_in when empty, otherwise mem[rd_ptr].
  - If empty with dst_rdy_in = 0, the push is stored normally.
- Undefined:
  - No combinational src-to-dst path.
  - Minimum latency is 1 cycle, as described above.

Test Plan:
- Reset check (DATA_W = 32, DEPTH = 4): hold reset_in high for 2 cycles while src_valid_in = 1 → src_rdy_out = 1, dst_valid_out = 0, count_out = 0, empty_out = 1; no entry stored after release.
- Fill and drain, dst_rdy_in = 0:
  - Push 0x11, 0x22, 0x33, 0x44 on consecutive cycles → count_out = 4, full_out = 1, src_rdy_out = 0.
  - A fifth push of 0x55 is refused.
  - Raise dst_rdy_in → outputs 0x11, 0x22, 0x33, 0x44 in order, then empty_out = 1.
- Streaming with wrap: push 10 values 0..9 with dst_rdy_in = 1 every cycle → pointers wrap past 3; outputs 0..9 in order; count_out never exceeds 1 in the non-bypass build, 0 in the bypass build.
- Full plus simultaneous pop: at count = 4 with src_valid_in = 1 and dst_rdy_in = 1 → the pop occurs, the push is refused, count_out = 3; the next cycle the push is accepted.
- Flush mid-stream: with count = 3, assert flush_in for 1 cycle together with src_valid_in = 1 and data 0xAA → next cycle count_out = 0; 0xAA is never output; subsequent push 0xBB is output first.
- Bypass build (PIPE_LINK_BYPASS_EN, empty, dst_rdy_in = 1): src_valid_in = 1, data 0xCAFE → dst_valid_out = 1 and dst_data_out = 0xCAFE in the same cycle; count_out remains 0.
